wb_dma_arbiter: RTL and testbench

Wishbone bus arbiter for the processor board. It shares the single 16-bit system bus between the 1801VM1 CPU master and up to NDMA DMA masters, such as disk and network controllers. It drives the CPU's bus-grant input and multiplexes the winning master onto the shared bus. DMA requesters are served round-robin, each with a bounded burst length and an idle timeout, and the CPU is guaranteed a minimum window between DMA tenures.

---
 rtl/dvk_bus_pkg.sv | 28 ++
 rtl/wb_dma_arbiter_rr_pick.sv | 28 ++
 rtl/wb_dma_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_wb_dma_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dvk_bus_pkg.sv
// Shared definitions for the board bus arbiter: state encoding, owner codes, slice widths.
package dvk_bus_pkg;

  localparam int unsigned SEL_W   = 2;
  localparam int unsigned ADR_W   = 16;
  localparam int unsigned DAT_W   = 16;
  localparam int unsigned OWNER_W = 3;

  localparam logic [OWNER_W-1:0] OWNER_CPU = 3'd0;

  typedef enum logic [1:0] {
    ST_CPU   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DMA   = 2'd2,
    ST_HOLD  = 2'd3
  } arb_state_t;

  // One master's request-side view of the bus
  typedef struct packed {
    logic             cyc;
    logic             stb;
    logic             we;
    logic [SEL_W-1:0] sel;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
  } wb_req_t;

endpackage

// File: rtl/wb_dma_arbiter_rr_pick.sv
// Round-robin selector: first set request strictly after last_served, wrapping.
module rr_pick #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_served,
  output logic [N-1:0]     winner,
  output logic             valid
);

  logic [IDX_W-1:0] idx;

  // Scan from last_served+1 around to last_served itself
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = IDX_W'((32'(last_served) + i) % N);
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_dma_arbiter.sv
// Arbiter sharing the 16-bit system bus between the CPU and NDMA round-robin DMA masters.
module wb_dma_arbiter
  import dvk_bus_pkg::*;
#(
  parameter int unsigned NDMA      = 2,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned CPU_MIN   = 4
) (
  input  logic                  clk_p,
  input  logic                  dclo,
  input  logic                  cpu_cyc_i,
  input  logic                  cpu_stb_i,
  input  logic                  cpu_we_i,
  input  logic [SEL_W-1:0]      cpu_sel_i,
  input  logic [ADR_W-1:0]      cpu_adr_i,
  input  logic [DAT_W-1:0]      cpu_dat_i,
  output logic                  cpu_gnt_o,
  output logic                  cpu_ack_o,
  input  logic [NDMA-1:0]       dma_req_i,
  output logic [NDMA-1:0]       dma_gnt_o,
  input  logic [NDMA-1:0]       dma_cyc_i,
  input  logic [NDMA-1:0]       dma_stb_i,
  input  logic [NDMA-1:0]       dma_we_i,
  input  logic [SEL_W*NDMA-1:0] dma_sel_i,
  input  logic [ADR_W*NDMA-1:0] dma_adr_i,
  input  logic [DAT_W*NDMA-1:0] dma_dat_i,
  output logic [NDMA-1:0]       dma_ack_o,
  output logic                  bus_cyc_o,
  output logic                  bus_stb_o,
  output logic                  bus_we_o,
  output logic [SEL_W-1:0]      bus_sel_o,
  output logic [ADR_W-1:0]      bus_adr_o,
  output logic [DAT_W-1:0]      bus_dat_o,
  input  logic                  bus_ack_i,
  output logic [OWNER_W-1:0]    owner_o
);

  localparam int unsigned IDX_W   = (NDMA > 1) ? $clog2(NDMA) : 1;
  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
  localparam int unsigned TO_W    = $clog2(TIMEOUT + 1);
  localparam int unsigned CMIN_W  = $clog2(CPU_MIN + 1);

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic [TO_W-1:0]     idle_q, idle_d;
  logic [CMIN_W-1:0]   cmin_q, cmin_d;
  logic                cpu_gnt_q, cpu_gnt_d;
  logic [NDMA-1:0]     dma_gnt_q, dma_gnt_d;
  logic [OWNER_W-1:0]  owner_q, owner_d;

  logic [NDMA-1:0]     pick_oh;
  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;
  logic                own_cyc;
  wb_req_t             bus_req;

  rr_pick #(.N(NDMA), .IDX_W(IDX_W)) u_rr_pick (
    .req         (dma_req_i),
    .last_served (last_q),
    .winner      (pick_oh),
    .valid       (pick_valid)
  );

  // One-hot winner to index
  always_comb begin
    pick_idx = '0;
    for (int unsigned k = 0; k < NDMA; k++) begin
      if (pick_oh[k]) pick_idx = IDX_W'(k);
    end
  end

  // State and grant registers; reset hands the bus to the CPU immediately
  always_ff @(posedge clk_p or posedge dclo) begin
    if (dclo) begin
      state_q   <= ST_CPU;
      win_q     <= '0;
      last_q    <= IDX_W'(NDMA - 1);
      burst_q   <= '0;
      idle_q    <= '0;
      cmin_q    <= '0;
      cpu_gnt_q <= 1'b1;
      dma_gnt_q <= '0;
      owner_q   <= OWNER_CPU;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      last_q    <= last_d;
      burst_q   <= burst_d;
      idle_q    <= idle_d;
      cmin_q    <= cmin_d;
      cpu_gnt_q <= cpu_gnt_d;
      dma_gnt_q <= dma_gnt_d;
      owner_q   <= owner_d;
    end
  end

  assign own_cyc = dma_cyc_i[win_q];

  // Next-state, counters and next grants
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    last_d    = last_q;
    burst_d   = burst_q;
    idle_d    = idle_q;
    cmin_d    = cmin_q;
    cpu_gnt_d = cpu_gnt_q;
    dma_gnt_d = dma_gnt_q;
    owner_d   = owner_q;
    unique case (state_q)
      ST_CPU: begin
        if (cmin_q != '0) begin
          cmin_d = cmin_q - CMIN_W'(1);
        end else if (pick_valid) begin
          state_d   = ST_DRAIN;
          win_d     = pick_idx;
          cpu_gnt_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (!cpu_cyc_i) begin
          if (dma_req_i[win_q]) begin
            state_d   = ST_DMA;
            dma_gnt_d = NDMA'(1) << win_q;
            owner_d   = OWNER_W'(win_q) + OWNER_W'(1);
            burst_d   = '0;
            idle_d    = '0;
          end else begin
            state_d   = ST_CPU;
            cpu_gnt_d = 1'b1;
          end
        end
      end
      ST_DMA: begin
        // Release only between cycles of the owner
        if (!own_cyc && (!dma_req_i[win_q] ||
                         burst_q == BURST_W'(MAX_BURST) ||
                         idle_q == TO_W'(TIMEOUT))) begin
          state_d   = ST_HOLD;
          last_d    = win_q;
          burst_d   = '0;
          idle_d    = '0;
          dma_gnt_d = '0;
          owner_d   = OWNER_CPU;
        end else begin
          if (bus_ack_i && own_cyc && burst_q != BURST_W'(MAX_BURST)) begin
            burst_d = burst_q + BURST_W'(1);
          end
          if (own_cyc) begin
            idle_d = '0;
          end else if (idle_q != TO_W'(TIMEOUT)) begin
            idle_d = idle_q + TO_W'(1);
          end
        end
      end
      ST_HOLD: begin
        state_d   = ST_CPU;
        cpu_gnt_d = 1'b1;
        cmin_d    = CMIN_W'(CPU_MIN);
      end
      default: begin
        state_d = ST_CPU;
      end
    endcase
  end

  // Shared bus mux; strobes are gated by the owner's grant
  always_comb begin
    bus_req = '{cyc: cpu_cyc_i & cpu_gnt_q, stb: cpu_stb_i & cpu_gnt_q, we: cpu_we_i,
                sel: cpu_sel_i, adr: cpu_adr_i, dat: cpu_dat_i};
    for (int unsigned k = 0; k < NDMA; k++) begin
      if (dma_gnt_q[k]) begin
        bus_req = '{cyc: dma_cyc_i[k], stb: dma_stb_i[k], we: dma_we_i[k],
                    sel: dma_sel_i[SEL_W*k +: SEL_W],
                    adr: dma_adr_i[ADR_W*k +: ADR_W],
                    dat: dma_dat_i[DAT_W*k +: DAT_W]};
      end
    end
  end

  assign bus_cyc_o = bus_req.cyc;
  assign bus_stb_o = bus_req.stb;
  assign bus_we_o  = bus_req.we;
  assign bus_sel_o = bus_req.sel;
  assign bus_adr_o = bus_req.adr;
  assign bus_dat_o = bus_req.dat;

  assign cpu_gnt_o = cpu_gnt_q;
  assign dma_gnt_o = dma_gnt_q;
  assign owner_o   = owner_q;
  assign cpu_ack_o = bus_ack_i & cpu_gnt_q;
  assign dma_ack_o = {NDMA{bus_ack_i}} & dma_gnt_q;

endmodule

// File: tb/tb_wb_dma_arbiter.sv
// Directed self-checking bench for wb_dma_arbiter with default parameters.
module tb_wb_dma_arbiter;

  localparam int unsigned NDMA = 2;

  logic              clk_p = 1'b0;
  logic              dclo;
  logic              cpu_cyc_i, cpu_stb_i, cpu_we_i;
  logic [1:0]        cpu_sel_i;
  logic [15:0]       cpu_adr_i, cpu_dat_i;
  logic              cpu_gnt_o, cpu_ack_o;
  logic [NDMA-1:0]   dma_req_i, dma_gnt_o, dma_cyc_i, dma_stb_i, dma_we_i, dma_ack_o;
  logic [2*NDMA-1:0] dma_sel_i;
  logic [16*NDMA-1:0] dma_adr_i, dma_dat_i;
  logic              bus_cyc_o, bus_stb_o, bus_we_o, bus_ack_i;
  logic [1:0]        bus_sel_o;
  logic [15:0]       bus_adr_o, bus_dat_o;
  logic [2:0]        owner_o;

  int checks   = 0;
  int failures = 0;
  logic [NDMA-1:0] mprev;

  always #5 clk_p = ~clk_p;

  // Zero-wait slave: acknowledges every strobed cycle in the same clock
  assign bus_ack_i = bus_cyc_o & bus_stb_o;

  wb_dma_arbiter dut (
    .clk_p(clk_p), .dclo(dclo),
    .cpu_cyc_i(cpu_cyc_i), .cpu_stb_i(cpu_stb_i), .cpu_we_i(cpu_we_i),
    .cpu_sel_i(cpu_sel_i), .cpu_adr_i(cpu_adr_i), .cpu_dat_i(cpu_dat_i),
    .cpu_gnt_o(cpu_gnt_o), .cpu_ack_o(cpu_ack_o),
    .dma_req_i(dma_req_i), .dma_gnt_o(dma_gnt_o),
    .dma_cyc_i(dma_cyc_i), .dma_stb_i(dma_stb_i), .dma_we_i(dma_we_i),
    .dma_sel_i(dma_sel_i), .dma_adr_i(dma_adr_i), .dma_dat_i(dma_dat_i),
    .dma_ack_o(dma_ack_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
    .bus_sel_o(bus_sel_o), .bus_adr_o(bus_adr_o), .bus_dat_o(bus_dat_o),
    .bus_ack_i(bus_ack_i), .owner_o(owner_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_p);
    #1;
  endtask

  // DMA master model: one single-cycle transfer, then one idle cycle, while granted
  task automatic drive_masters();
    for (int k = 0; k < int'(NDMA); k++) begin
      dma_cyc_i[k] = dma_gnt_o[k] & ~mprev[k];
      dma_stb_i[k] = dma_cyc_i[k];
      mprev[k]     = dma_cyc_i[k];
    end
  endtask

  task automatic do_reset();
    dclo      = 1'b1;
    dma_req_i = '0;
    dma_cyc_i = '0;
    dma_stb_i = '0;
    cpu_cyc_i = 1'b0;
    cpu_stb_i = 1'b0;
    mprev     = '0;
    tick();
    dclo = 1'b0;
  endtask

  initial begin
    int acks, phase, gap, cpu_cnt, n, cpu_win, gcnt;
    logic prev_any, seen;
    logic [2:0] owners [4];

    cpu_we_i  = 1'b0; cpu_sel_i = 2'b00; cpu_adr_i = '0; cpu_dat_i = '0;
    dma_we_i  = '0;   dma_sel_i = '0;
    dma_adr_i = {16'h0200, 16'h0100};
    dma_dat_i = {16'hBBBB, 16'hAAAA};
    do_reset();
    dclo = 1'b1;
    tick();

    // Reset values
    chk("rst_cpu_gnt", cpu_gnt_o, 1);
    chk("rst_dma_gnt", dma_gnt_o, 0);
    chk("rst_owner", owner_o, 0);
    dclo = 1'b0;
    tick();

    // CPU write to 0o177600 passes through
    cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1; cpu_we_i = 1'b1;
    cpu_sel_i = 2'b11; cpu_adr_i = 16'hFF80; cpu_dat_i = 16'h1234;
    #1;
    chk("cpu_wr_adr", bus_adr_o, 16'hFF80);
    chk("cpu_wr_dat", bus_dat_o, 16'h1234);
    chk("cpu_wr_we", bus_we_o, 1);
    chk("cpu_wr_cyc", bus_cyc_o, 1);
    chk("cpu_wr_ack", cpu_ack_o, 1);
    chk("cpu_wr_dma_ack", dma_ack_o, 0);

    // Request during a CPU cycle: grant removed next edge, DMA waits for cyc low
    dma_req_i = 2'b01;
    tick();
    chk("drain_cpu_gnt", cpu_gnt_o, 0);
    chk("drain_bus_cyc", bus_cyc_o, 0);
    chk("drain_cpu_ack", cpu_ack_o, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_hold_dma_gnt", dma_gnt_o, 0);
    end
    cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0; cpu_we_i = 1'b0;
    tick();
    chk("dma0_gnt", dma_gnt_o, 2'b01);
    chk("dma0_owner", owner_o, 1);
    chk("dma0_cpu_gnt", cpu_gnt_o, 0);
    dma_cyc_i = 2'b01; dma_stb_i = 2'b01;
    #1;
    chk("dma0_bus_adr", bus_adr_o, 16'h0100);
    chk("dma0_bus_cyc", bus_cyc_o, 1);
    chk("dma0_ack", dma_ack_o, 2'b01);
    chk("dma0_cpu_ack", cpu_ack_o, 0);
    tick();
    dma_cyc_i = '0; dma_stb_i = '0; dma_req_i = '0;
    tick();
    chk("hold_dma_gnt", dma_gnt_o, 0);
    chk("hold_cpu_gnt", cpu_gnt_o, 0);
    chk("hold_owner", owner_o, 0);
    tick();
    chk("back_cpu_gnt", cpu_gnt_o, 1);

    // CPU window ignores requests for CPU_MIN cycles, then drain; drop request in drain
    cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1;
    dma_req_i = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("cpu_window_gnt", cpu_gnt_o, 1);
    end
    tick();
    chk("window_end_drain", cpu_gnt_o, 0);
    dma_req_i = '0; cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0;
    tick();
    chk("req_drop_cpu_gnt", cpu_gnt_o, 1);
    chk("req_drop_dma_gnt", dma_gnt_o, 0);

    // Burst limit: exactly 16 acks, then 7 cycles off the bus (5 of them CPU-granted)
    do_reset();
    dma_req_i = 2'b01;
    acks = 0; phase = 0; gap = 0; cpu_cnt = 0;
    for (int c = 0; c < 300 && phase < 3; c++) begin
      tick();
      drive_masters();
      #1;
      case (phase)
        0: if (dma_gnt_o[0]) begin phase = 1; if (dma_ack_o[0]) acks++; end
        1: if (!dma_gnt_o[0]) begin phase = 2; gap = 1; end
           else if (dma_ack_o[0]) acks++;
        default: if (dma_gnt_o[0]) phase = 3;
                 else begin gap++; if (cpu_gnt_o) cpu_cnt++; end
      endcase
    end
    chk("burst_done", phase, 3);
    chk("burst_acks", acks, 16);
    chk("burst_gap", gap, 7);
    chk("burst_cpu_window", cpu_cnt, 5);

    // Round-robin with both requesting continuously
    do_reset();
    dma_req_i = 2'b11;
    n = 0; cpu_win = 0; prev_any = 1'b0;
    for (int i = 0; i < 4; i++) owners[i] = 3'd0;
    for (int c = 0; c < 1000 && n < 4; c++) begin
      tick();
      drive_masters();
      #1;
      if (dma_gnt_o != '0 && !prev_any) begin
        if (n > 0) chk("rr_cpu_window", cpu_win, 5);
        owners[n] = owner_o;
        n++;
        cpu_win = 0;
      end
      if (cpu_gnt_o) cpu_win++;
      prev_any = |dma_gnt_o;
    end
    chk("rr_tenures", n, 4);
    chk("rr_owner0", owners[0], 1);
    chk("rr_owner1", owners[1], 2);
    chk("rr_owner2", owners[2], 1);
    chk("rr_owner3", owners[3], 2);

    // Idle timeout: DMA1 granted, never asserts cyc
    do_reset();
    dma_req_i = 2'b10;
    gcnt = 0; seen = 1'b0; phase = 0;
    for (int c = 0; c < 300 && phase == 0; c++) begin
      tick();
      if (dma_gnt_o[1]) begin seen = 1'b1; gcnt++; end
      else if (seen) phase = 1;
    end
    dma_req_i = '0;
    chk("to_released", phase, 1);
    // Grant seen after the granting edge plus 64 counting edges, released on the next
    chk("to_gnt_cycles", gcnt, 65);
    chk("to_owner_hold", owner_o, 0);
    tick();
    chk("to_cpu_gnt", cpu_gnt_o, 1);
    chk("to_owner_cpu", owner_o, 0);

    // Asynchronous reset during a DMA0 transfer
    do_reset();
    dma_req_i = 2'b01;
    tick();
    tick();
    chk("mid_dma_gnt", dma_gnt_o, 2'b01);
    dma_cyc_i = 2'b01; dma_stb_i = 2'b01;
    #2;
    dclo = 1'b1;
    #1;
    chk("mid_rst_dma_gnt", dma_gnt_o, 0);
    chk("mid_rst_cpu_gnt", cpu_gnt_o, 1);
    chk("mid_rst_owner", owner_o, 0);
    chk("mid_rst_bus_cyc", bus_cyc_o, 0);
    tick();
    dclo = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
